mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle main controller for an RV32I datapath.
//
// Sequences FETCH / DECODE / EXEC / MEM / WB and drives all per-cycle strobes
// for PC, IR, register file and data memory. Both memory ports use a
// request/ready handshake with variable latency. A wait counter traps to TRAP
// when a request stays unanswered for TIMEOUT cycles (TIMEOUT = 0 disables it).
// Unknown opcodes also trap. TRAP is left only through rst.
//
// Optional feature: define MC_CTRL_PERF_CNT_EN to add the 32-bit performance
// counters instret (retired instructions) and stall_cyc (cycles that a memory
// request spends waiting for ready).
module mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       br_take,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic [1:0] wd_sel,
  output logic [2:0] dm_type,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout,
  output logic       retire
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] stall_cyc
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JAL   = 2'd2;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  // The counter only ever has to hold values 0 .. TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  // Ungated strobes; forced to zero while rst is high before reaching ports.
  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_write_c, pc_write_c;
  logic       reg_write_c, retire_c;
  logic [1:0] pc_sel_c, wd_sel_c;
  logic [2:0] dm_type_c;
  logic       wait_expired;
  logic       is_load, is_store;

  // Access size/sign code presented to the data memory.
  function automatic logic [2:0] decode_dm_type(input logic [2:0] f3);
    case (f3)
      3'b000:  decode_dm_type = 3'b011;  // byte
      3'b001:  decode_dm_type = 3'b001;  // half
      3'b010:  decode_dm_type = 3'b000;  // word
      3'b100:  decode_dm_type = 3'b100;  // byte unsigned
      3'b101:  decode_dm_type = 3'b010;  // half unsigned
      default: decode_dm_type = 3'b000;
    endcase
  endfunction

  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_LUI: op_known = 1'b1;
      default:                                       op_known = 1'b0;
    endcase
  endfunction

  assign is_load      = (Op == OP_L);
  assign is_store     = (Op == OP_S);
  assign wait_expired = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

  // Next-state, trap flags and raw strobes for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = PC_PLUS4;
    reg_write_c = 1'b0;
    wd_sel_c    = WD_ALU;
    dm_type_c   = 3'b000;
    retire_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_sel_c   = PC_PLUS4;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end

      S_DECODE: begin
        if (op_known(Op)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end

      S_EXEC: begin
        case (Op)
          OP_R, OP_I, OP_LUI: state_d = S_WB;
          OP_L, OP_S:         state_d = S_MEM;
          OP_B: begin
            pc_write_c = br_take;
            pc_sel_c   = PC_BR;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: begin
            pc_write_c  = 1'b1;
            pc_sel_c    = PC_JAL;
            reg_write_c = 1'b1;
            wd_sel_c    = WD_LINK;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            // IR changed under us; treat it like an undecodable opcode.
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        dm_type_c  = decode_dm_type(Funct3);
        if (dmem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        wd_sel_c    = is_load ? WD_MEM : WD_ALU;
        dm_type_c   = decode_dm_type(Funct3);
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase

    // Wait counter: counts unanswered request cycles, cleared on any move.
    wait_cnt_d = '0;
    if (state_d == state_q &&
        ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // State register, wait counter and sticky trap flags.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // Port drive: everything is held at zero while rst is asserted.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'd0;
    reg_write = 1'b0;
    wd_sel    = 2'd0;
    dm_type   = 3'd0;
    state     = 3'd0;
    illegal   = 1'b0;
    timeout   = 1'b0;
    retire    = 1'b0;
    if (!rst) begin
      imem_req  = imem_req_c;
      dmem_req  = dmem_req_c;
      dmem_we   = dmem_we_c;
      ir_write  = ir_write_c;
      pc_write  = pc_write_c;
      pc_sel    = pc_sel_c;
      reg_write = reg_write_c;
      wd_sel    = wd_sel_c;
      dm_type   = dm_type_c;
      state     = state_q;
      illegal   = illegal_q;
      timeout   = timeout_q;
      retire    = retire_c;
    end
  end

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;

  // Retired-instruction and memory-stall counters; both wrap at 2^32.
  always_comb begin
    instret_d   = instret_q;
    stall_cyc_d = stall_cyc_q;
    if (retire) begin
      instret_d = instret_q + 32'd1;
    end
    if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      instret_q   <= instret_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign instret   = instret_q;
  assign stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl (TIMEOUT = 16). Each step drives inputs just
// after a rising edge, pushes the expected outputs onto a scoreboard queue and
// compares them against the DUT at the following falling edge.
module tb_mc_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] wd_sel;
    logic [2:0] dm_type;
    logic [2:0] state;
    logic       illegal;
    logic       timeout;
    logic       retire;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       br_take;
  logic       imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic       ir_write, pc_write, reg_write, illegal, timeout, retire;
  logic [1:0] pc_sel, wd_sel;
  logic [2:0] dm_type, state;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instret, stall_cyc;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .Funct3     (Funct3),
    .br_take    (br_take),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .reg_write  (reg_write),
    .wd_sel     (wd_sel),
    .dm_type    (dm_type),
    .state      (state),
    .illegal    (illegal),
    .timeout    (timeout),
    .retire     (retire)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .instret    (instret),
    .stall_cyc  (stall_cyc)
`endif
  );

  // Field order: state, imem_req, dmem_req, dmem_we, ir_write, pc_write,
  // pc_sel, reg_write, wd_sel, dm_type, illegal, timeout, retire.
  function automatic obs_t mk(input logic [2:0] st, input logic im, input logic dq,
                              input logic we, input logic irw, input logic pcw,
                              input logic [1:0] pcs, input logic rw, input logic [1:0] wds,
                              input logic [2:0] dmt, input logic ill, input logic to,
                              input logic ret);
    obs_t o;
    o.state = st;  o.imem_req = im;   o.dmem_req = dq;  o.dmem_we = we;
    o.ir_write = irw; o.pc_write = pcw; o.pc_sel = pcs; o.reg_write = rw;
    o.wd_sel = wds; o.dm_type = dmt; o.illegal = ill; o.timeout = to;
    o.retire = ret;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.state = state;  o.imem_req = imem_req; o.dmem_req = dmem_req;
    o.dmem_we = dmem_we; o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_sel = pc_sel; o.reg_write = reg_write; o.wd_sel = wd_sel;
    o.dm_type = dm_type; o.illegal = illegal; o.timeout = timeout;
    o.retire = retire;
    return o;
  endfunction

  // One clock cycle: drive, queue the expectation, compare, advance.
  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic [2:0] f3, input logic bt, input logic ir,
                      input logic dr, input obs_t ex);
    obs_t  got, want;
    string t;
    rst = r; Op = op; Funct3 = f3; br_take = bt; imem_ready = ir; dmem_ready = dr;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = observe();
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %05h (state %0d) expected %05h (state %0d)",
             t, got, got.state, want, want.state);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t z, f_ok, f_wait, dec, exe, trap_ill, trap_to;
    z        = mk(3'd0, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0);
    f_ok     = mk(3'd0, 1,0,0,1,1, 2'd0, 0, 2'd0, 3'd0, 0,0,0);
    f_wait   = mk(3'd0, 1,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0);
    dec      = mk(3'd1, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0);
    exe      = mk(3'd2, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0);
    trap_ill = mk(3'd5, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 1,0,0);
    trap_to  = mk(3'd5, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,1,0);

    // Reset: all outputs forced to zero, even with readies high.
    step("reset0", 1, OP_R, 3'b011, 0, 1, 1, z);
    step("reset1", 1, OP_R, 3'b011, 0, 1, 1, z);

    // R-type, readies tied high: 0,1,2,4 then back to FETCH.
    step("r_fetch", 0, OP_R, 3'b011, 0, 1, 1, f_ok);
    step("r_dec",   0, OP_R, 3'b011, 0, 1, 1, dec);
    step("r_exec",  0, OP_R, 3'b011, 0, 1, 1, exe);
    step("r_wb",    0, OP_R, 3'b011, 0, 1, 1, mk(3'd4, 0,0,0,0,0, 2'd0, 1, 2'd0, 3'd0, 0,0,1));

    // LW with dmem_ready delayed 3 cycles: MEM held 4 cycles.
    step("lw_fetch", 0, OP_L, 3'b010, 0, 1, 0, f_ok);
    step("lw_dec",   0, OP_L, 3'b010, 0, 0, 0, dec);
    step("lw_exec",  0, OP_L, 3'b010, 0, 0, 0, exe);
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 0, OP_L, 3'b010, 0, 1, 0, mk(3'd3, 0,1,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0));
    step("lw_mem_rdy", 0, OP_L, 3'b010, 0, 0, 1, mk(3'd3, 0,1,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0));
    step("lw_wb",      0, OP_L, 3'b010, 0, 0, 1, mk(3'd4, 0,0,0,0,0, 2'd0, 1, 2'd1, 3'd0, 0,0,1));

    // LHU, zero-wait: half-unsigned access code in MEM and WB.
    step("lhu_fetch", 0, OP_L, 3'b101, 0, 1, 1, f_ok);
    step("lhu_dec",   0, OP_L, 3'b101, 0, 1, 1, dec);
    step("lhu_exec",  0, OP_L, 3'b101, 0, 1, 1, exe);
    step("lhu_mem",   0, OP_L, 3'b101, 0, 1, 1, mk(3'd3, 0,1,0,0,0, 2'd0, 0, 2'd0, 3'b010, 0,0,0));
    step("lhu_wb",    0, OP_L, 3'b101, 0, 1, 1, mk(3'd4, 0,0,0,0,0, 2'd0, 1, 2'd1, 3'b010, 0,0,1));

    // SB with spurious readies in DECODE/EXEC, then one wait cycle in MEM.
    step("sb_fetch",    0, OP_S, 3'b000, 0, 1, 0, f_ok);
    step("sb_dec",      0, OP_S, 3'b000, 0, 1, 1, dec);
    step("sb_exec",     0, OP_S, 3'b000, 0, 1, 1, exe);
    step("sb_mem_wait", 0, OP_S, 3'b000, 0, 1, 0, mk(3'd3, 0,1,1,0,0, 2'd0, 0, 2'd0, 3'b011, 0,0,0));
    step("sb_mem_rdy",  0, OP_S, 3'b000, 0, 0, 1, mk(3'd3, 0,1,1,0,0, 2'd0, 0, 2'd0, 3'b011, 0,0,1));
    step("sb_refetch",  0, OP_S, 3'b000, 0, 0, 1, f_wait);

    // BEQ taken then not taken.
    step("beq1_fetch", 0, OP_B, 3'b000, 1, 1, 0, f_ok);
    step("beq1_dec",   0, OP_B, 3'b000, 1, 0, 0, dec);
    step("beq1_exec",  0, OP_B, 3'b000, 1, 0, 0, mk(3'd2, 0,0,0,0,1, 2'd1, 0, 2'd0, 3'd0, 0,0,1));
    step("beq0_fetch", 0, OP_B, 3'b000, 0, 1, 0, f_ok);
    step("beq0_dec",   0, OP_B, 3'b000, 0, 0, 0, dec);
    step("beq0_exec",  0, OP_B, 3'b000, 0, 0, 0, mk(3'd2, 0,0,0,0,0, 2'd1, 0, 2'd0, 3'd0, 0,0,1));

    // JAL and LUI.
    step("jal_fetch", 0, OP_JAL, 3'b000, 0, 1, 0, f_ok);
    step("jal_dec",   0, OP_JAL, 3'b000, 0, 0, 0, dec);
    step("jal_exec",  0, OP_JAL, 3'b000, 0, 0, 0, mk(3'd2, 0,0,0,0,1, 2'd2, 1, 2'd2, 3'd0, 0,0,1));
    step("lui_fetch", 0, OP_LUI, 3'b111, 0, 1, 0, f_ok);
    step("lui_dec",   0, OP_LUI, 3'b111, 0, 0, 0, dec);
    step("lui_exec",  0, OP_LUI, 3'b111, 0, 0, 0, exe);
    step("lui_wb",    0, OP_LUI, 3'b111, 0, 0, 0, mk(3'd4, 0,0,0,0,0, 2'd0, 1, 2'd0, 3'd0, 0,0,1));

    // Reset in the middle of a load: no strobes, no retire, back to FETCH.
    step("mid_fetch", 0, OP_L, 3'b010, 0, 1, 0, f_ok);
    step("mid_dec",   0, OP_L, 3'b010, 0, 0, 0, dec);
    step("mid_exec",  0, OP_L, 3'b010, 0, 0, 0, exe);
    step("mid_rst",   1, OP_L, 3'b010, 0, 1, 1, z);
    step("mid_after", 0, OP_L, 3'b010, 0, 0, 0, f_wait);

    // Illegal opcode: TRAP with illegal set, absorbing for 20 cycles.
    step("ill_fetch", 0, OP_BAD, 3'b000, 0, 1, 0, f_ok);
    step("ill_dec",   0, OP_BAD, 3'b000, 0, 0, 0, dec);
    for (int i = 0; i < 20; i++)
      step("ill_trap", 0, OP_BAD, 3'b000, 1, 1, 1, trap_ill);
    step("ill_rst",   1, OP_BAD, 3'b000, 0, 0, 0, z);
    step("ill_clear", 0, OP_R,   3'b011, 0, 0, 0, f_wait);

    // Fetch timeout: 16 unanswered FETCH cycles then TRAP with timeout set.
    step("to_rst", 1, OP_L, 3'b010, 0, 0, 0, z);
    for (int i = 0; i < 16; i++)
      step("to_fetch_wait", 0, OP_L, 3'b010, 0, 0, 0, f_wait);
    step("to_trap0", 0, OP_L, 3'b010, 0, 1, 1, trap_to);
    step("to_trap1", 0, OP_L, 3'b010, 0, 1, 1, trap_to);

    // Ready on the 16th FETCH cycle wins over the timeout.
    step("late_rst", 1, OP_L, 3'b010, 0, 0, 0, z);
    for (int i = 0; i < 15; i++)
      step("late_fetch_wait", 0, OP_L, 3'b010, 0, 0, 0, f_wait);
    step("late_fetch_rdy", 0, OP_L, 3'b010, 0, 1, 0, f_ok);
    step("late_dec",       0, OP_L, 3'b010, 0, 0, 0, dec);
    step("late_exec",      0, OP_L, 3'b010, 0, 0, 0, exe);

    // Data-memory timeout: 16 unanswered MEM cycles then TRAP.
    for (int i = 0; i < 16; i++)
      step("mem_to_wait", 0, OP_L, 3'b010, 0, 1, 0, mk(3'd3, 0,1,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0));
    step("mem_to_trap", 0, OP_L, 3'b010, 0, 1, 1, trap_to);
    step("final_rst",   1, OP_L, 3'b010, 0, 0, 0, z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
